// File: rtl/sprite_sched_pkg.sv
// Shared types and helpers for the sprite motion scheduler.
// Build option: SPRITE_SCHED_WRAP_EN (see sprite_axis_step / sprite_motion_sched).
package sprite_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UPDATE  = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    typedef logic signed [3:0] vel_t;

    localparam vel_t VEL_MAX = 4'sd7;
    localparam vel_t VEL_MIN = -4'sd8;

    // Reverse a velocity; -8 has no positive twin in 4 bits, so it saturates to +7.
    function automatic vel_t vel_neg(input vel_t v);
        return (v == VEL_MIN) ? VEL_MAX : -v;
    endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis position/velocity step with edge handling.
// Build option: SPRITE_SCHED_WRAP_EN defined -> wrap at the edges, otherwise bounce.
module sprite_axis_step
    import sprite_sched_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int MAX     = 540
) (
    input  logic [COORD_W-1:0] pos,
    input  vel_t               vel,
    output logic [COORD_W-1:0] pos_nxt,
    output vel_t               vel_nxt
);

    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

    // Two guard bits keep the sum's sign and overflow visible.
    logic signed [SW-1:0] n;
    assign n = $signed({2'b00, pos}) + $signed({{(SW-4){vel[3]}}, vel});

`ifdef SPRITE_SCHED_WRAP_EN
    localparam logic [COORD_W-1:0] SPAN = COORD_W'(MAX + 1);

    // Wrap to the opposite edge; velocity is left alone.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pos_nxt = n[COORD_W-1:0];
        vel_nxt = vel;
        if (n < 0) begin
            pos_nxt = n[COORD_W-1:0] + SPAN;
        end else if (n > MAX_S) begin
            pos_nxt = n[COORD_W-1:0] - SPAN;
        end
    end
`else
    localparam logic [COORD_W-1:0] MAX_C = COORD_W'(MAX);

    // Bounce: clamp to the edge and reverse the velocity.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pos_nxt = n[COORD_W-1:0];
        vel_nxt = vel;
        if (n < 0) begin
            pos_nxt = '0;
            vel_nxt = vel_neg(vel);
        end else if (n > MAX_S) begin
            pos_nxt = MAX_C;
            vel_nxt = vel_neg(vel);
        end
    end
`endif

endmodule

// File: rtl/sprite_motion_sched.sv
// Frame-synchronous motion scheduler: steps NUM_SPR sprites once every FRAME_DIV
// frames through one shared x/y step unit and publishes a coherent position set.
// Build option: SPRITE_SCHED_WRAP_EN defined -> sprites wrap at the edges instead of bouncing.
module sprite_motion_sched
    import sprite_sched_pkg::*;
#(
    parameter int NUM_SPR   = 4,
    parameter int COORD_W   = 10,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int SPR_SIZE  = 100,
    parameter int FRAME_DIV = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       frame_tick,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [$clog2(NUM_SPR)-1:0] cfg_sel,
    input  logic [COORD_W-1:0]         cfg_x,
    input  logic [COORD_W-1:0]         cfg_y,
    input  logic [3:0]                 cfg_vx,
    input  logic [3:0]                 cfg_vy,
    output logic [NUM_SPR*COORD_W-1:0] spr_x,
    output logic [NUM_SPR*COORD_W-1:0] spr_y,
    output logic                       upd_done,
    output logic                       overrun
);

    localparam int SEL_W = $clog2(NUM_SPR);
    localparam int XMAX  = H_ACTIVE - SPR_SIZE;
    localparam int YMAX  = V_ACTIVE - SPR_SIZE;
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [COORD_W-1:0] XMAX_C   = COORD_W'(XMAX);
    localparam logic [COORD_W-1:0] YMAX_C   = COORD_W'(YMAX);
    localparam logic [SEL_W-1:0]   LAST_IDX = SEL_W'(NUM_SPR - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FRAME_DIV - 1);

    state_t             state;
    logic [SEL_W-1:0]   idx;
    logic [DIV_W-1:0]   div_cnt;

    // Working copy, stepped during UPDATE; spr_x/spr_y hold the published copy.
    logic [COORD_W-1:0] wx  [NUM_SPR];
    logic [COORD_W-1:0] wy  [NUM_SPR];
    vel_t               wvx [NUM_SPR];
    vel_t               wvy [NUM_SPR];

    // Single-entry host write slot.
    logic               pend_valid;
    logic [SEL_W-1:0]   pend_sel;
    logic [COORD_W-1:0] pend_x;
    logic [COORD_W-1:0] pend_y;
    vel_t               pend_vx;
    vel_t               pend_vy;

    logic [COORD_W-1:0] step_x, step_y, ld_x, ld_y;
    vel_t               step_vx, step_vy;

    assign cfg_ready = !pend_valid;

    // Host positions are clamped into the visible area when loaded.
    assign ld_x = (pend_x > XMAX_C) ? XMAX_C : pend_x;
    assign ld_y = (pend_y > YMAX_C) ? YMAX_C : pend_y;

    sprite_axis_step #(.COORD_W(COORD_W), .MAX(XMAX)) u_step_x (
        .pos     (wx[idx]),
        .vel     (wvx[idx]),
        .pos_nxt (step_x),
        .vel_nxt (step_vx)
    );

    sprite_axis_step #(.COORD_W(COORD_W), .MAX(YMAX)) u_step_y (
        .pos     (wy[idx]),
        .vel     (wvy[idx]),
        .pos_nxt (step_y),
        .vel_nxt (step_vy)
    );

    // Scheduler FSM, host write slot, working sprite state and published outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            div_cnt    <= '0;
            upd_done   <= 1'b0;
            overrun    <= 1'b0;
            pend_valid <= 1'b0;
            pend_sel   <= '0;
            pend_x     <= '0;
            pend_y     <= '0;
            pend_vx    <= '0;
            pend_vy    <= '0;
            // NOTE: the sprite table is a handful of flops, not a RAM, so it takes its start-up values from reset.
            for (int i = 0; i < NUM_SPR; i++) begin
                wx[i]                        <= COORD_W'(i * SPR_SIZE);
                wy[i]                        <= '0;
                wvx[i]                       <= 4'sd1;
                wvy[i]                       <= 4'sd1;
                spr_x[i*COORD_W +: COORD_W]  <= COORD_W'(i * SPR_SIZE);
                spr_y[i*COORD_W +: COORD_W]  <= '0;
            end
        end else begin
            // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
            upd_done <= 1'b0;

            if (cfg_valid && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_sel   <= cfg_sel;
                pend_x     <= cfg_x;
                pend_y     <= cfg_y;
                pend_vx    <= vel_t'(cfg_vx);
                pend_vy    <= vel_t'(cfg_vy);
            end

            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            idx     <= '0;
                            state   <= UPDATE;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end

                UPDATE: begin
                    if (frame_tick) overrun <= 1'b1;
                    if (pend_valid && (pend_sel == idx)) begin
                        wx[idx]    <= ld_x;
                        wy[idx]    <= ld_y;
                        wvx[idx]   <= pend_vx;
                        wvy[idx]   <= pend_vy;
                        pend_valid <= 1'b0;
                    end else begin
                        wx[idx]  <= step_x;
                        wy[idx]  <= step_y;
                        wvx[idx] <= step_vx;
                        wvy[idx] <= step_vy;
                    end
                    if (idx == LAST_IDX) begin
                        state    <= PUBLISH;
                        upd_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                PUBLISH: begin
                    if (frame_tick) overrun <= 1'b1;
                    for (int i = 0; i < NUM_SPR; i++) begin
                        spr_x[i*COORD_W +: COORD_W] <= wx[i];
                        spr_y[i*COORD_W +: COORD_W] <= wy[i];
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_sched.sv
// Scoreboard bench for sprite_motion_sched: each update pass pushes its expected
// published set and publish cycle; a monitor pops on every upd_done pulse.
module tb_sprite_motion_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        frame_tick3 = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_valid3 = 1'b0;
    logic [1:0]  cfg_sel = '0;
    logic [9:0]  cfg_x = '0;
    logic [9:0]  cfg_y = '0;
    logic [3:0]  cfg_vx = '0;
    logic [3:0]  cfg_vy = '0;
    logic        cfg_ready, cfg_ready3;
    logic [39:0] spr_x, spr_y, spr_x3, spr_y3;
    logic        upd_done, upd_done3, overrun, overrun3;

    sprite_motion_sched dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
        .spr_x(spr_x), .spr_y(spr_y), .upd_done(upd_done), .overrun(overrun)
    );

    sprite_motion_sched #(.FRAME_DIV(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick3),
        .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_sel(cfg_sel),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
        .spr_x(spr_x3), .spr_y(spr_y3), .upd_done(upd_done3), .overrun(overrun3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [39:0] x;
        logic [39:0] y;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          sb3[$];
    int          tick3_num = 0;
    logic [39:0] pub_x, pub_y;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [39:0] p4(input int a, input int b, input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic note_fail(input string msg);
        n_checks++;
        $display("FAIL %s (cycle %0d)", msg, cyc);
    endtask

    // Main DUT monitor: latency, coherence while publishing, and the new set.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (upd_done === 1'b1) begin
                if (sb.size() == 0) begin
                    note_fail("unexpected_upd_done: pulse with no pass outstanding");
                end else begin
                    e = sb.pop_front();
                    check("upd_done_cycle", 64'(cyc), 64'(e.cyc));
                    check("coherent_x_during_publish", spr_x, pub_x);
                    check("coherent_y_during_publish", spr_y, pub_y);
                    @(negedge clk);
                    check("spr_x", spr_x, e.x);
                    check("spr_y", spr_y, e.y);
                    pub_x = e.x;
                    pub_y = e.y;
                end
            end
        end
    end

    // FRAME_DIV=3 monitor: each pulse must follow the expected tick number.
    initial begin
        int k;
        forever begin
            @(negedge clk);
            if (upd_done3 === 1'b1) begin
                if (sb3.size() == 0) begin
                    note_fail("div3_unexpected_upd_done");
                end else begin
                    k = sb3.pop_front();
                    check("div3_pass_tick", 64'(tick3_num), 64'(k));
                end
            end
        end
    end

    task automatic tick(input bit push, input logic [39:0] ex, input logic [39:0] ey);
        @(posedge clk); #1;
        frame_tick = 1'b1;
        if (push) sb.push_back('{ex, ey, cyc + 5});
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            note_fail("pass_timeout: upd_done never arrived");
            sb.delete();
        end
    endtask

    task automatic pass(input logic [39:0] ex, input logic [39:0] ey);
        tick(1'b1, ex, ey);
        drain();
    endtask

    task automatic cfg_write(input logic [1:0] s, input int x, input int y,
                             input logic [3:0] vx, input logic [3:0] vy);
        int  n = 0;
        logic r = 1'b0;
        @(posedge clk); #1;
        cfg_sel = s; cfg_x = 10'(x); cfg_y = 10'(y); cfg_vx = vx; cfg_vy = vy;
        cfg_valid = 1'b1;
        do begin
            @(negedge clk);
            r = cfg_ready;
            @(posedge clk);
            n++;
        end while (!r && n < 200);
        #1 cfg_valid = 1'b0;
        if (!r) note_fail("cfg_accept_timeout");
    endtask

    task automatic rst_pulse();
        @(posedge clk); #1;
        reset_n = 1'b0;
        sb.delete();
        pub_x = p4(0, 100, 200, 300);
        pub_y = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        pub_x = p4(0, 100, 200, 300);
        pub_y = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Idle after reset: reset positions stay published, no passes.
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check("reset_spr_x", spr_x, p4(0, 100, 200, 300));
        check("reset_spr_y", spr_y, '0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_cfg_ready", cfg_ready, 1'b1);

        // First pass: every sprite moves +1,+1.
        pass(p4(1, 101, 201, 301), p4(1, 1, 1, 1));

        // Host write to sprite 2 near the right edge, then the edge reaction.
        cfg_write(2'd2, 538, 0, 4'h3, 4'hE);
        @(negedge clk);
        check("cfg_ready_pending", cfg_ready, 1'b0);
        pass(p4(2, 102, 538, 302), p4(2, 2, 0, 2));
        check("cfg_ready_consumed", cfg_ready, 1'b1);
`ifdef SPRITE_SCHED_WRAP_EN
        pass(p4(3, 103, 0, 303), p4(3, 3, 379, 3));
        pass(p4(4, 104, 3, 304), p4(4, 4, 377, 4));
`else
        pass(p4(3, 103, 540, 303), p4(3, 3, 0, 3));
        pass(p4(4, 104, 537, 304), p4(4, 4, 2, 4));
`endif

        // Tick during UPDATE: sticky overrun, no extra pass.
        check("overrun_before", overrun, 1'b0);
`ifdef SPRITE_SCHED_WRAP_EN
        tick(1'b1, p4(5, 105, 6, 305), p4(5, 5, 375, 5));
`else
        tick(1'b1, p4(5, 105, 534, 305), p4(5, 5, 4, 5));
`endif
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        check("overrun_sticky", overrun, 1'b1);

        // Reset mid-UPDATE with a write pending: everything back to reset state.
        cfg_write(2'd0, 77, 77, 4'h0, 4'h0);
        tick(1'b0, '0, '0);
        reset_n = 1'b0;
        sb.delete();
        pub_x = p4(0, 100, 200, 300);
        pub_y = '0;
        @(negedge clk);
        check("midpass_reset_spr_x", spr_x, p4(0, 100, 200, 300));
        check("midpass_reset_spr_y", spr_y, '0);
        check("midpass_reset_overrun", overrun, 1'b0);
        check("midpass_reset_cfg_ready", cfg_ready, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1 reset_n = 1'b1;
        pass(p4(1, 101, 201, 301), p4(1, 1, 1, 1));

        // Second request held while the slot is full; accepted mid-pass after idx 0.
        cfg_write(2'd1, 1, 700, 4'hD, 4'h7);
        @(posedge clk); #1;
        cfg_sel = 2'd0; cfg_x = 10'd10; cfg_y = 10'd20; cfg_vx = 4'h0; cfg_vy = 4'h0;
        cfg_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("cfg_ready_held_low", cfg_ready, 1'b0);
        tick(1'b1, p4(2, 1, 202, 302), p4(2, 380, 2, 2));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cfg_ready !== 1'b1 && n < 50);
        @(posedge clk); #1 cfg_valid = 1'b0;
        if (n >= 50) note_fail("second_write_timeout");
        drain();
        check("cfg_ready_second_pending", cfg_ready, 1'b0);
`ifdef SPRITE_SCHED_WRAP_EN
        pass(p4(10, 539, 203, 303), p4(20, 6, 3, 3));
        check("cfg_ready_second_consumed", cfg_ready, 1'b1);
        pass(p4(10, 536, 204, 304), p4(20, 13, 4, 4));
`else
        pass(p4(10, 0, 203, 303), p4(20, 380, 3, 3));
        check("cfg_ready_second_consumed", cfg_ready, 1'b1);
        pass(p4(10, 3, 204, 304), p4(20, 373, 4, 4));
`endif

        // Velocity -8 at the low edges.
        rst_pulse();
        cfg_write(2'd3, 5, 0, 4'h8, 4'h8);
        pass(p4(1, 101, 201, 5), p4(1, 1, 1, 0));
`ifdef SPRITE_SCHED_WRAP_EN
        pass(p4(2, 102, 202, 538), p4(2, 2, 2, 373));
        pass(p4(3, 103, 203, 530), p4(3, 3, 3, 365));
`else
        pass(p4(2, 102, 202, 0), p4(2, 2, 2, 0));
        pass(p4(3, 103, 203, 7), p4(3, 3, 3, 7));
`endif

        // Sprite at x=1 moving -3: bounce to 0 or wrap to 539.
        rst_pulse();
        cfg_write(2'd0, 1, 0, 4'hD, 4'h0);
        pass(p4(1, 101, 201, 301), p4(0, 1, 1, 1));
`ifdef SPRITE_SCHED_WRAP_EN
        pass(p4(539, 102, 202, 302), p4(0, 2, 2, 2));
        pass(p4(536, 103, 203, 303), p4(0, 3, 3, 3));
`else
        pass(p4(0, 102, 202, 302), p4(0, 2, 2, 2));
        pass(p4(3, 103, 203, 303), p4(0, 3, 3, 3));
`endif

        // FRAME_DIV=3 instance: passes on ticks 3, 6 and 9 only.
        rst_pulse();
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            frame_tick3 = 1'b1;
            tick3_num = k;
            if (k % 3 == 0) sb3.push_back(k);
            @(posedge clk); #1 frame_tick3 = 1'b0;
            repeat (8) @(posedge clk);
        end
        repeat (10) @(negedge clk);
        check("div3_pending_passes", 64'(sb3.size()), 64'd0);
        check("div3_spr_x", spr_x3, p4(3, 103, 203, 303));
        check("div3_spr_y", spr_y3, p4(3, 3, 3, 3));
        check("div3_overrun", overrun3, 1'b0);
        check("div3_cfg_ready", cfg_ready3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
